uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_pkg.sv | 46 ++++
 rtl/uart_cmd_parser_pulse.sv | 33 +++
 rtl/uart_cmd_parser.sv | 162 ++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants, FSM state type and letter decode helpers for the UART
// command parser.
package uart_cmd_pkg;

    localparam logic [7:0] ASCII_HASH = 8'h23;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_ESC  = 8'h1B;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;

    // Command letter table, channel 0 in the low byte: H, M, S, R, C
    localparam int MAX_CMD = 5;
    localparam logic [MAX_CMD-1:0][7:0] CMD_LETTER = {8'h43, 8'h52, 8'h53, 8'h4D, 8'h48};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_NUM  = 2'd2
    } state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } letter_t;

    function automatic logic [7:0] to_upper(input logic [7:0] b);
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
        return b;
    endfunction

    // Map a byte to an enabled channel; only the first num_cmd letters count.
    function automatic letter_t decode_letter(input logic [7:0] b, input int num_cmd);
        letter_t    r;
        logic [7:0] u;
        r = '0;
        u = to_upper(b);
        for (int i = 0; i < MAX_CMD; i++) begin
            if (i < num_cmd && !r.hit && u == CMD_LETTER[i]) begin
                r.hit = 1'b1;
                r.idx = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_cmd_parser_pulse.sv
// cmd_pulse_stretch: holds a loaded one-hot value for PULSE_LEN cycles;
// a new load replaces the value and restarts the count.
module cmd_pulse_stretch #(
    parameter int NUM_CMD   = 5,
    parameter int PULSE_LEN = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [NUM_CMD-1:0] onehot,
    output logic [NUM_CMD-1:0] control
);

    localparam logic [7:0] RELOAD = 8'(PULSE_LEN - 1);

    logic [7:0] cnt;

    // Load/hold/expire the pulse; cnt counts the remaining high cycles after this one
    always_ff @(posedge clk) begin
        if (reset) begin
            control <= '0;
            cnt     <= '0;
        end else if (load) begin
            control <= onehot;
            cnt     <= RELOAD;
        end else if (cnt != 8'd0) begin
            cnt     <= cnt - 8'd1;
        end else begin
            control <= '0;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command parser: single letters fire command pulses, "#<letter><digits>\r"
// loads set_idx/set_value. Optional idle abort of open set-sequences is built
// when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int NUM_CMD     = 5,
    parameter int ARG_W       = 7,
    parameter int ARG_DIGITS  = 2,
    parameter int PULSE_LEN   = 1,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         data,
    input  logic               data_valid,
    output logic [NUM_CMD-1:0] control,
    output logic               set_valid,
    output logic [2:0]         set_idx,
    output logic [ARG_W-1:0]   set_value,
    output logic               err
);

    localparam int               ACC_W   = ARG_W + 5;
    localparam logic [ARG_W-1:0] ARG_MAX = '1;
    localparam logic [1:0]       DIG_MAX = 2'(ARG_DIGITS);

    state_t           state, state_nxt;
    letter_t          lt;
    logic             is_digit;
    logic [3:0]       digit;
    logic [ARG_W-1:0] acc, acc_sat;
    logic [ACC_W-1:0] prod;
    logic [1:0]       dcnt;
    logic [2:0]       idx;
    logic [NUM_CMD-1:0] onehot;
    logic             fire_cmd, fire_sel, fire_dig, fire_set, fire_err;
    logic             timeout;

    assign lt       = decode_letter(data, NUM_CMD);
    assign is_digit = (data >= ASCII_ZERO) && (data <= ASCII_NINE);
    assign digit    = 4'(data - ASCII_ZERO);
    assign prod     = {5'b0, acc} * ACC_W'(10) + ACC_W'(digit);
    assign acc_sat  = (prod > ACC_W'(ARG_MAX)) ? ARG_MAX : prod[ARG_W-1:0];

    // One-hot select of the decoded channel
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_CMD; i++) onehot[i] = (lt.idx == 3'(i));
    end

`ifdef UART_CMD_TIMEOUT_EN
    localparam int            TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] idle_cnt;

    // Count consecutive byte-free cycles while a set-sequence is open
    always_ff @(posedge clk) begin
        if (reset || data_valid || state == ST_IDLE) idle_cnt <= '0;
        else if (!timeout)                           idle_cnt <= idle_cnt + 1'b1;
    end

    assign timeout = (state != ST_IDLE) && !data_valid && (idle_cnt == TO_LAST);
`else
    assign timeout = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // FSM next state; ESC always returns to IDLE, any NUM exit other than a digit ends the sequence
    always_comb begin
        state_nxt = state;
        if (data_valid && data == ASCII_ESC) begin
            state_nxt = ST_IDLE;
        end else if (data_valid) begin
            case (state)
                ST_IDLE: if (data == ASCII_HASH) state_nxt = ST_SEL;
                ST_SEL:  state_nxt = lt.hit ? ST_NUM : ST_IDLE;
                ST_NUM:  if (!(is_digit && dcnt < DIG_MAX)) state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end else if (timeout) begin
            state_nxt = ST_IDLE;
        end
    end

    // FSM actions for the current byte
    always_comb begin
        fire_cmd = 1'b0;
        fire_sel = 1'b0;
        fire_dig = 1'b0;
        fire_set = 1'b0;
        fire_err = 1'b0;
        if (data_valid && data != ASCII_ESC) begin
            case (state)
                ST_IDLE: fire_cmd = lt.hit;
                ST_SEL: begin
                    fire_sel = lt.hit;
                    fire_err = !lt.hit;
                end
                ST_NUM: begin
                    if (is_digit) begin
                        if (dcnt < DIG_MAX) fire_dig = 1'b1;
                        else                fire_err = 1'b1;
                    end else if (data == ASCII_CR) begin
                        if (dcnt != 2'd0) fire_set = 1'b1;
                        else              fire_err = 1'b1;
                    end else begin
                        fire_err = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (!data_valid && timeout) begin
            fire_err = 1'b1;
        end
    end

    // Argument accumulator and registered set/err outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            dcnt      <= '0;
            idx       <= '0;
            set_idx   <= '0;
            set_value <= '0;
            set_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (fire_sel) begin
                idx  <= lt.idx;
                acc  <= '0;
                dcnt <= '0;
            end else if (fire_dig) begin
                acc  <= acc_sat;
                dcnt <= dcnt + 2'd1;
            end
            if (fire_set) begin
                set_idx   <= idx;
                set_value <= acc;
            end
            set_valid <= fire_set;
            err       <= fire_err;
        end
    end

    cmd_pulse_stretch #(
        .NUM_CMD  (NUM_CMD),
        .PULSE_LEN(PULSE_LEN)
    ) u_pulse (
        .clk    (clk),
        .reset  (reset),
        .load   (fire_cmd),
        .onehot (onehot),
        .control(control)
    );

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: two instances (A: PULSE_LEN=3, ARG_W=7;
// B: PULSE_LEN=1, ARG_W=4) share one byte stream. Expected output events are
// queued with the cycle they must appear in; per-instance monitors compare.
module tb_uart_cmd_parser;

    logic       clk;
    logic       reset;
    logic [7:0] data;
    logic       dv;

    logic [4:0] a_ctrl, b_ctrl;
    logic       a_sv, b_sv, a_err, b_err;
    logic [2:0] a_idx, b_idx;
    logic [6:0] a_val;
    logic [3:0] b_val;

    uart_cmd_parser #(.NUM_CMD(5), .ARG_W(7), .ARG_DIGITS(2), .PULSE_LEN(3), .TIMEOUT_CYC(20)) dut_a (
        .clk(clk), .reset(reset), .data(data), .data_valid(dv),
        .control(a_ctrl), .set_valid(a_sv), .set_idx(a_idx), .set_value(a_val), .err(a_err));

    uart_cmd_parser #(.NUM_CMD(5), .ARG_W(4), .ARG_DIGITS(2), .PULSE_LEN(1), .TIMEOUT_CYC(20)) dut_b (
        .clk(clk), .reset(reset), .data(data), .data_valid(dv),
        .control(b_ctrl), .set_valid(b_sv), .set_idx(b_idx), .set_value(b_val), .err(b_err));

    typedef struct {
        int         st;
        logic [4:0] ctrl;
        logic       sv;
        logic       er;
        logic [2:0] idx;
        logic [6:0] val;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   last_st;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    endtask

    task automatic bad(input string nm, input logic [4:0] c, input logic sv, input logic er);
        n_chk++;
        $display("FAIL %s: ctrl=%b set_valid=%b err=%b (cycle %0d)", nm, c, sv, er, cyc);
    endtask

    task automatic cmp_entry(input string nm, input exp_t e, input logic [4:0] c, input logic sv,
                             input logic er, input logic [2:0] i, input logic [6:0] v);
        chk({nm, "_control"}, 32'(c), 32'(e.ctrl));
        chk({nm, "_set_valid"}, 32'(sv), 32'(e.sv));
        chk({nm, "_err"}, 32'(er), 32'(e.er));
        if (e.sv) begin
            chk({nm, "_set_idx"}, 32'(i), 32'(e.idx));
            chk({nm, "_set_value"}, 32'(v), 32'(e.val));
        end
    endtask

    // Monitor A: compare at each negedge against the event due this cycle
    always @(negedge clk) begin : mon_a
        exp_t e;
        while (qa.size() > 0 && qa[0].st < cyc) begin
            bad("A_missed_event", a_ctrl, a_sv, a_err);
            void'(qa.pop_front());
        end
        if (qa.size() > 0 && qa[0].st == cyc) begin
            e = qa.pop_front();
            cmp_entry("A", e, a_ctrl, a_sv, a_err, a_idx, a_val);
        end else if (a_ctrl != 5'd0 || a_sv || a_err) begin
            bad("A_unexpected_output", a_ctrl, a_sv, a_err);
        end
    end

    // Monitor B
    always @(negedge clk) begin : mon_b
        exp_t e;
        while (qb.size() > 0 && qb[0].st < cyc) begin
            bad("B_missed_event", b_ctrl, b_sv, b_err);
            void'(qb.pop_front());
        end
        if (qb.size() > 0 && qb[0].st == cyc) begin
            e = qb.pop_front();
            cmp_entry("B", e, b_ctrl, b_sv, b_err, b_idx, {3'b0, b_val});
        end else if (b_ctrl != 5'd0 || b_sv || b_err) begin
            bad("B_unexpected_output", b_ctrl, b_sv, b_err);
        end
    end

    function automatic exp_t mk(input int st, input logic [4:0] c, input logic sv, input logic er,
                                input logic [2:0] i, input logic [6:0] v);
        exp_t e;
        e.st = st; e.ctrl = c; e.sv = sv; e.er = er; e.idx = i; e.val = v;
        return e;
    endfunction

    // Both instances flag err in the cycle after the offending byte
    task automatic exp_err(input int st);
        qa.push_back(mk(st, 5'd0, 1'b0, 1'b1, 3'd0, 7'd0));
        qb.push_back(mk(st, 5'd0, 1'b0, 1'b1, 3'd0, 7'd0));
    endtask

    task automatic exp_set(input int st, input logic [2:0] i, input logic [6:0] va, input logic [6:0] vb);
        qa.push_back(mk(st, 5'd0, 1'b1, 1'b0, i, va));
        qb.push_back(mk(st, 5'd0, 1'b1, 1'b0, i, vb));
    endtask

    // A holds 3 cycles, B holds 1 cycle
    task automatic exp_pulse(input int st, input logic [4:0] c);
        for (int k = 0; k < 3; k++) qa.push_back(mk(st + k, c, 1'b0, 1'b0, 3'd0, 7'd0));
        qb.push_back(mk(st, c, 1'b0, 1'b0, 3'd0, 7'd0));
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        data    = b;
        dv      = 1'b1;
        last_st = cyc + 1;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            dv = 1'b0;
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_A_control"}, 32'(a_ctrl), 32'd0);
        chk({tag, "_A_set_valid"}, 32'(a_sv), 32'd0);
        chk({tag, "_A_set_idx"}, 32'(a_idx), 32'd0);
        chk({tag, "_A_set_value"}, 32'(a_val), 32'd0);
        chk({tag, "_A_err"}, 32'(a_err), 32'd0);
        chk({tag, "_B_control"}, 32'(b_ctrl), 32'd0);
        chk({tag, "_B_set_idx"}, 32'(b_idx), 32'd0);
        chk({tag, "_B_set_value"}, 32'(b_val), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        reset = 1'b1;
        dv    = 1'b0;
        data  = 8'h00;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;
        gap(2);

        // single lowercase command letter
        send("m");  exp_pulse(last_st, 5'b00010);
        gap(5);

        // set-sequence; letter in SEL produces no pulse; B saturates 45 -> 15
        send_str("#S45\r"); exp_set(last_st, 3'd2, 7'd45, 7'd15);
        gap(3);

        // too many digits, trailing CR ignored in IDLE
        send_str("#H12"); send("3"); exp_err(last_st);
        send("\r");
        gap(3);

        send_str("#R99\r"); exp_set(last_st, 3'd3, 7'd99, 7'd15);
        gap(3);
        send_str("#s7\r");  exp_set(last_st, 3'd2, 7'd7, 7'd7);
        gap(3);

        // ignored bytes in IDLE, then malformed sequences
        send("x"); send("5"); send("\r");
        gap(2);
        send_str("#X");     exp_err(last_st);
        gap(2);
        send_str("##");     exp_err(last_st);
        gap(2);
        send_str("#M\r");   exp_err(last_st);
        gap(2);
        send_str("#S4a");   exp_err(last_st);
        gap(2);
        send_str("#h1H");   exp_err(last_st);
        gap(2);
        send_str("#S4"); send(8'h1B); send("\r");
        gap(3);

        // new command restarts an active pulse
        send("h");
        qa.push_back(mk(last_st,     5'b00001, 1'b0, 1'b0, 3'd0, 7'd0));
        qa.push_back(mk(last_st + 1, 5'b00001, 1'b0, 1'b0, 3'd0, 7'd0));
        qb.push_back(mk(last_st,     5'b00001, 1'b0, 1'b0, 3'd0, 7'd0));
        gap(1);
        send("c");  exp_pulse(last_st, 5'b10000);
        gap(5);

        // idle gap inside an open set-sequence
        send_str("#S4");
`ifdef UART_CMD_TIMEOUT_EN
        exp_err(last_st + 20);
        gap(25);
        send("5"); send("\r");
`else
        gap(25);
        send("5"); send("\r"); exp_set(last_st, 3'd2, 7'd45, 7'd15);
`endif
        gap(3);

        // reset mid-sequence clears state and held outputs
        send_str("#C");
        @(negedge clk);
        dv    = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("midreset");
        reset = 1'b0;
        gap(1);
        send("4"); send("\r");
        gap(2);
        send("C");  exp_pulse(last_st, 5'b10000);
        gap(6);

        chk("A_queue_drained", 32'(qa.size()), 32'd0);
        chk("B_queue_drained", 32'(qb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
